// File: rtl/escape_pkg.sv
// Shared types and sizes for the escape-time sequencer.
package escape_pkg;

  localparam int unsigned NUM_LANES  = 4;
  localparam int unsigned PIPE_DEPTH = 4;
  localparam int unsigned COORD_W    = 32;
  localparam int unsigned LANE_W     = 2;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    LOAD,
    RUN,
    DRAIN
  } state_e;

  typedef struct packed {
    logic [COORD_W-1:0] a;
    logic [COORD_W-1:0] b;
  } coord_t;

endpackage

// File: rtl/escape_sequencer_lane_demux.sv
// Demultiplexes the engine's serial diverged bit into per-lane escape flags and counts.
module lane_demux
  import escape_pkg::*;
#(
  parameter int unsigned MAX_ITER   = 256,
  parameter int unsigned ITER_W     = 9,
  parameter int unsigned DIV_OFFSET = 1
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              clr_i,
  input  logic                              en_i,
  input  logic [LANE_W-1:0]                 phase_i,
  input  logic [ITER_W-1:0]                 iter_i,
  input  logic                              diverged_i,
  output logic [NUM_LANES-1:0]              esc_o,
  output logic [NUM_LANES-1:0][ITER_W-1:0]  cnt_o
);

  localparam int unsigned T_W = ITER_W + LANE_W;

  logic [NUM_LANES-1:0]             esc_q;
  logic [NUM_LANES-1:0][ITER_W-1:0] cnt_q;

  logic [T_W-1:0]    t_c;
  logic [T_W-1:0]    adj_c;
  logic [LANE_W-1:0] lane_c;
  logic [ITER_W-1:0] round_c;
  logic              hit_c;

  // The bit seen DIV_OFFSET cycles late belongs to an earlier (lane, round) slot.
  always_comb begin
    t_c     = {iter_i, phase_i};
    adj_c   = t_c - T_W'(DIV_OFFSET);
    lane_c  = adj_c[LANE_W-1:0];
    round_c = adj_c[T_W-1:LANE_W];
    hit_c   = en_i && diverged_i && (t_c >= T_W'(DIV_OFFSET)) && !esc_q[lane_c];
  end

  // First divergence per lane wins; clear presets the cap so silent lanes report MAX_ITER.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      esc_q <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      esc_q <= '0;
      for (int i = 0; i < int'(NUM_LANES); i++) cnt_q[i] <= ITER_W'(MAX_ITER);
    end else if (hit_c) begin
      esc_q[lane_c] <= 1'b1;
      cnt_q[lane_c] <= round_c;
    end
  end

  assign esc_o = esc_q;
  assign cnt_o = cnt_q;

endmodule

// File: rtl/escape_sequencer.sv
// Batches coordinates into four engine lanes, runs the engine and serialises per-lane results.
module escape_sequencer
  import escape_pkg::*;
#(
  parameter int unsigned MAX_ITER   = 256,
  parameter int unsigned ITER_W     = 9,
  parameter int unsigned DIV_OFFSET = 1
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               cfg_julia,
  input  logic [COORD_W-1:0] cfg_ca,
  input  logic [COORD_W-1:0] cfg_cb,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [COORD_W-1:0] s_a,
  input  logic [COORD_W-1:0] s_b,
  input  logic               s_last,
  output logic               ld,
  output logic [COORD_W-1:0] a1,
  output logic [COORD_W-1:0] a2,
  output logic [COORD_W-1:0] a3,
  output logic [COORD_W-1:0] a4,
  output logic [COORD_W-1:0] b1,
  output logic [COORD_W-1:0] b2,
  output logic [COORD_W-1:0] b3,
  output logic [COORD_W-1:0] b4,
  output logic [COORD_W-1:0] julia_a0,
  output logic [COORD_W-1:0] julia_b0,
  output logic               julia_VS_mandelbrot,
  input  logic               diverged,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [ITER_W-1:0]  m_iter,
  output logic               m_escaped,
  output logic               m_last
);

  localparam logic [LANE_W-1:0] LD_LAST   = LANE_W'(PIPE_DEPTH - 1);
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(NUM_LANES - 1);

  state_e                           state_q;
  coord_t                           lane_q [NUM_LANES];
  logic [NUM_LANES-1:0]             vld_q;
  logic [LANE_W-1:0]                k_q;
  logic                             last_seen_q;
  logic [LANE_W-1:0]                last_lane_q;
  logic [LANE_W-1:0]                ld_cnt_q;
  logic [LANE_W-1:0]                phase_q;
  logic [ITER_W-1:0]                iter_q;
  logic [LANE_W:0]                  drain_q;
  logic                             s_ready_q;
  logic                             ld_q;
  logic                             m_valid_q;
  logic [ITER_W-1:0]                m_iter_q;
  logic                             m_escaped_q;
  logic                             m_last_q;
  logic [COORD_W-1:0]               julia_a_q;
  logic [COORD_W-1:0]               julia_b_q;
  logic                             julia_q;

  logic [NUM_LANES-1:0]             esc_c;
  logic [NUM_LANES-1:0][ITER_W-1:0] cnt_c;
  logic                             all_done_c;
  logic                             nxt_found_c;
  logic [LANE_W-1:0]                nxt_idx_c;

  lane_demux #(
    .MAX_ITER   (MAX_ITER),
    .ITER_W     (ITER_W),
    .DIV_OFFSET (DIV_OFFSET)
  ) u_lane_demux (
    .clk_i      (aclk),
    .rst_i      (areset),
    .clr_i      (state_q == LOAD),
    .en_i       (state_q == RUN),
    .phase_i    (phase_q),
    .iter_i     (iter_q),
    .diverged_i (diverged),
    .esc_o      (esc_c),
    .cnt_o      (cnt_c)
  );

  // Batch is finished once every real lane has escaped; pad lanes never hold it open.
  assign all_done_c = &(esc_c | ~vld_q);

  // Lowest populated lane at or above the drain pointer.
  always_comb begin
    nxt_found_c = 1'b0;
    nxt_idx_c   = '0;
    for (int i = int'(NUM_LANES) - 1; i >= 0; i--) begin
      if (i >= int'(drain_q) && vld_q[i]) begin
        nxt_found_c = 1'b1;
        nxt_idx_c   = LANE_W'(i);
      end
    end
  end

  // Sequencer FSM with packer, load/run counters and result serialiser.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= IDLE;
      for (int i = 0; i < int'(NUM_LANES); i++) lane_q[i] <= '0;
      vld_q       <= '0;
      k_q         <= '0;
      last_seen_q <= 1'b0;
      last_lane_q <= '0;
      ld_cnt_q    <= '0;
      phase_q     <= '0;
      iter_q      <= '0;
      drain_q     <= '0;
      s_ready_q   <= 1'b0;
      ld_q        <= 1'b1;
      m_valid_q   <= 1'b0;
      m_iter_q    <= '0;
      m_escaped_q <= 1'b0;
      m_last_q    <= 1'b0;
      julia_a_q   <= '0;
      julia_b_q   <= '0;
      julia_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q   <= COLLECT;
          s_ready_q <= 1'b1;
          ld_q      <= 1'b0;
          k_q       <= '0;
          vld_q     <= '0;
        end
        COLLECT: begin
          // A frame terminator with nothing pending is consumed silently.
          if (s_valid && s_ready_q && !(s_last && k_q == '0)) begin
            lane_q[k_q] <= '{a: s_a, b: s_b};
            vld_q[k_q]  <= 1'b1;
            k_q         <= k_q + LANE_W'(1);
            if (s_last || k_q == LANE_LAST) begin
              state_q     <= LOAD;
              s_ready_q   <= 1'b0;
              ld_q        <= 1'b1;
              ld_cnt_q    <= '0;
              last_seen_q <= s_last;
              last_lane_q <= k_q;
              julia_a_q   <= cfg_ca;
              julia_b_q   <= cfg_cb;
              julia_q     <= cfg_julia;
            end
          end
        end
        LOAD: begin
          ld_cnt_q <= ld_cnt_q + LANE_W'(1);
          if (ld_cnt_q == LD_LAST) begin
            state_q <= RUN;
            ld_q    <= 1'b0;
            phase_q <= '0;
            iter_q  <= '0;
          end
        end
        RUN: begin
          phase_q <= phase_q + LANE_W'(1);
          if (phase_q == LANE_LAST) iter_q <= iter_q + ITER_W'(1);
          if (all_done_c || iter_q == ITER_W'(MAX_ITER)) begin
            state_q   <= DRAIN;
            drain_q   <= '0;
            m_valid_q <= 1'b0;
          end
        end
        DRAIN: begin
          if (!m_valid_q || m_ready) begin
            if (nxt_found_c) begin
              m_valid_q   <= 1'b1;
              m_iter_q    <= cnt_c[nxt_idx_c];
              m_escaped_q <= esc_c[nxt_idx_c];
              m_last_q    <= last_seen_q && (nxt_idx_c == last_lane_q);
              drain_q     <= (LANE_W + 1)'(nxt_idx_c) + (LANE_W + 1)'(1);
            end else begin
              state_q     <= COLLECT;
              m_valid_q   <= 1'b0;
              m_last_q    <= 1'b0;
              s_ready_q   <= 1'b1;
              k_q         <= '0;
              vld_q       <= '0;
              last_seen_q <= 1'b0;
              for (int i = 0; i < int'(NUM_LANES); i++) lane_q[i] <= '0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_ready             = s_ready_q;
  assign ld                  = ld_q;
  assign a1                  = lane_q[0].a;
  assign a2                  = lane_q[1].a;
  assign a3                  = lane_q[2].a;
  assign a4                  = lane_q[3].a;
  assign b1                  = lane_q[0].b;
  assign b2                  = lane_q[1].b;
  assign b3                  = lane_q[2].b;
  assign b4                  = lane_q[3].b;
  assign julia_a0            = julia_a_q;
  assign julia_b0            = julia_b_q;
  assign julia_VS_mandelbrot = julia_q;
  assign m_valid             = m_valid_q;
  assign m_iter              = m_iter_q;
  assign m_escaped           = m_escaped_q;
  assign m_last              = m_last_q;

endmodule

// File: tb/tb_escape_sequencer.sv
// Directed bench for escape_sequencer with hand-computed expected results.
module tb_escape_sequencer;

  logic        aclk;
  logic        areset;
  logic        cfg_julia;
  logic [31:0] cfg_ca, cfg_cb;
  logic        s_valid, s_ready, s_last;
  logic [31:0] s_a, s_b;
  logic        ld;
  logic [31:0] a1, a2, a3, a4, b1, b2, b3, b4;
  logic [31:0] julia_a0, julia_b0;
  logic        julia_VS_mandelbrot;
  logic        diverged;
  logic        m_valid, m_ready;
  logic [8:0]  m_iter;
  logic        m_escaped, m_last;

  int n_cmp = 0;
  int n_err = 0;
  int div_mode = 0;   // 0: never, 1: every cycle, 2: only at run cycle div_t
  int div_t = 0;
  int t_b = -1;

  escape_sequencer dut (
    .aclk                (aclk),
    .areset              (areset),
    .cfg_julia           (cfg_julia),
    .cfg_ca              (cfg_ca),
    .cfg_cb              (cfg_cb),
    .s_valid             (s_valid),
    .s_ready             (s_ready),
    .s_a                 (s_a),
    .s_b                 (s_b),
    .s_last              (s_last),
    .ld                  (ld),
    .a1                  (a1),
    .a2                  (a2),
    .a3                  (a3),
    .a4                  (a4),
    .b1                  (b1),
    .b2                  (b2),
    .b3                  (b3),
    .b4                  (b4),
    .julia_a0            (julia_a0),
    .julia_b0            (julia_b0),
    .julia_VS_mandelbrot (julia_VS_mandelbrot),
    .diverged            (diverged),
    .m_valid             (m_valid),
    .m_ready             (m_ready),
    .m_iter              (m_iter),
    .m_escaped           (m_escaped),
    .m_last              (m_last)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Run cycle t_b counts from 0 on the first cycle ld is low after a load.
  initial begin
    diverged = 1'b0;
    forever begin
      @(negedge aclk);
      if (ld) t_b = -1;
      else    t_b = t_b + 1;
      diverged = (div_mode == 1) || (div_mode == 2 && t_b == div_t);
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic last);
    int n = 0;
    s_valid = 1'b1; s_a = a; s_b = b; s_last = last;
    while (s_ready !== 1'b1 && n < 200) begin
      @(negedge aclk);
      n++;
    end
    check_eq("send_ready_wait", 64'(n < 200), 64'(1));
    @(negedge aclk);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_run();
    int n = 0;
    while (ld !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
    while (ld !== 1'b0 && n < 50) begin @(negedge aclk); n++; end
    check_eq("run_start_wait", 64'(n < 50), 64'(1));
  endtask

  task automatic recv(input logic [8:0] e_iter, input logic e_esc, input logic e_last, input int stall);
    int n = 0;
    while (m_valid !== 1'b1 && n < 3000) begin @(negedge aclk); n++; end
    check_eq("recv_valid_wait", 64'(n < 3000), 64'(1));
    for (int i = 0; i < stall; i++) begin
      check_eq("stall_m_valid", 64'(m_valid), 64'(1));
      check_eq("stall_m_iter", 64'(m_iter), 64'(e_iter));
      check_eq("stall_s_ready", 64'(s_ready), 64'(0));
      @(negedge aclk);
    end
    check_eq("m_iter", 64'(m_iter), 64'(e_iter));
    check_eq("m_escaped", 64'(m_escaped), 64'(e_esc));
    check_eq("m_last", 64'(m_last), 64'(e_last));
    m_ready = 1'b1;
    @(negedge aclk);
    m_ready = 1'b0;
  endtask

  task automatic expect_idle_collect(input string tag);
    repeat (3) @(negedge aclk);
    check_eq({tag, "_m_valid"}, 64'(m_valid), 64'(0));
    check_eq({tag, "_s_ready"}, 64'(s_ready), 64'(1));
    check_eq({tag, "_ld"}, 64'(ld), 64'(0));
  endtask

  initial begin
    int n;
    areset = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_a = '0; s_b = '0;
    m_ready = 1'b0; cfg_julia = 1'b0; cfg_ca = '0; cfg_cb = '0;
    repeat (2) @(negedge aclk);

    // Reset values
    check_eq("rst_s_ready", 64'(s_ready), 64'(0));
    check_eq("rst_ld", 64'(ld), 64'(1));
    check_eq("rst_m_valid", 64'(m_valid), 64'(0));
    check_eq("rst_a1", 64'(a1), 64'(0));
    check_eq("rst_m_iter", 64'(m_iter), 64'(0));
    check_eq("rst_julia_a0", 64'(julia_a0), 64'(0));
    areset = 1'b0;
    @(negedge aclk);
    check_eq("collect_s_ready", 64'(s_ready), 64'(1));
    check_eq("collect_ld", 64'(ld), 64'(0));

    // Terminator with no pending lane: no batch
    send(32'h1, 32'h2, 1'b1);
    expect_idle_collect("empty_last");

    // Lane 2 diverges at run cycle 15 -> lane (15-1)%4=2, round 14/4=3
    div_mode = 2; div_t = 15;
    for (int i = 0; i < 4; i++) send(32'(10 + i), 32'(20 + i), 1'b0);
    recv(9'd256, 1'b0, 1'b0, 0);
    recv(9'd256, 1'b0, 1'b0, 0);
    recv(9'd3,   1'b1, 1'b0, 0);
    recv(9'd256, 1'b0, 1'b0, 0);
    expect_idle_collect("t1_end");

    // Three points, last on the third: partial batch, ld high four cycles
    div_mode = 1;
    send(32'h31, 32'h41, 1'b0);
    send(32'h32, 32'h42, 1'b0);
    send(32'h33, 32'h43, 1'b1);
    n = 0;
    while (ld === 1'b1 && n < 20) begin n++; @(negedge aclk); end
    check_eq("t2_ld_cycles", 64'(n), 64'(4));
    check_eq("t2_a3", 64'(a3), 64'(32'h33));
    check_eq("t2_pad_a4", 64'(a4), 64'(0));
    check_eq("t2_pad_b4", 64'(b4), 64'(0));
    recv(9'd0, 1'b1, 1'b0, 0);
    recv(9'd0, 1'b1, 1'b0, 0);
    recv(9'd0, 1'b1, 1'b1, 0);
    expect_idle_collect("t2_no_pad");

    // All lanes diverge every cycle; stall first result for 20 cycles
    div_mode = 1;
    for (int i = 0; i < 4; i++) send(32'(50 + i), 32'(60 + i), 1'b0);
    recv(9'd0, 1'b1, 1'b0, 20);
    for (int i = 0; i < 3; i++) recv(9'd0, 1'b1, 1'b0, 0);
    expect_idle_collect("t3_end");

    // Julia constant latched at load, changed during run
    cfg_julia = 1'b1; cfg_ca = 32'hFFF0_0000; cfg_cb = 32'h0010_0000;
    for (int i = 0; i < 4; i++) send(32'(100 + i), 32'(110 + i), 1'b0);
    wait_run();
    cfg_ca = 32'h1234_5678; cfg_cb = 32'h0; cfg_julia = 1'b0;
    repeat (2) @(negedge aclk);
    check_eq("t5_julia_a0", 64'(julia_a0), 64'(32'hFFF0_0000));
    check_eq("t5_julia_b0", 64'(julia_b0), 64'(32'h0010_0000));
    check_eq("t5_julia_sel", 64'(julia_VS_mandelbrot), 64'(1));
    check_eq("t5_a4", 64'(a4), 64'(103));
    check_eq("t5_b1", 64'(b1), 64'(110));
    for (int i = 0; i < 4; i++) recv(9'd0, 1'b1, 1'b0, 0);

    // Next batch picks up the new constant; reset it mid-run
    div_mode = 0;
    for (int i = 0; i < 4; i++) send(32'(200 + i), 32'(210 + i), 1'b0);
    wait_run();
    check_eq("t5_next_julia_a0", 64'(julia_a0), 64'(32'h1234_5678));
    check_eq("t5_next_julia_sel", 64'(julia_VS_mandelbrot), 64'(0));
    check_eq("t6_pre_a1", 64'(a1), 64'(200));
    repeat (10) @(negedge aclk);
    #2 areset = 1'b1;
    #1;
    check_eq("t6_async_ld", 64'(ld), 64'(1));
    check_eq("t6_async_s_ready", 64'(s_ready), 64'(0));
    check_eq("t6_async_m_valid", 64'(m_valid), 64'(0));
    check_eq("t6_async_a1", 64'(a1), 64'(0));
    check_eq("t6_async_julia_a0", 64'(julia_a0), 64'(0));
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    check_eq("t6_restart_s_ready", 64'(s_ready), 64'(1));
    check_eq("t6_restart_m_valid", 64'(m_valid), 64'(0));

    // Clean restart: two-point frame lands in lanes 0 and 1
    div_mode = 1;
    send(32'd300, 32'd400, 1'b0);
    send(32'd301, 32'd401, 1'b1);
    check_eq("t6_a1", 64'(a1), 64'(300));
    check_eq("t6_a2", 64'(a2), 64'(301));
    check_eq("t6_pad_a3", 64'(a3), 64'(0));
    recv(9'd0, 1'b1, 1'b0, 0);
    recv(9'd0, 1'b1, 1'b1, 0);
    expect_idle_collect("t6_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
